junction_cycle_ctrl: RTL and testbench

JUNCTION_CYCLE_CTRL -- requirements
Module: junction_cycle_ctrl

---
 rtl/dnn_pkg.sv | 30 +++
 rtl/junc_index_gen.sv | 22 ++
 rtl/junction_cycle_ctrl.sv | 140 ++++++++++++++
 tb/tb_junction_cycle_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared types and constants for the junction cycle controller.
package dnn_pkg;

    // Controller phases: waiting, presenting inputs, flushing the pipeline.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } cyc_state_e;

    // Upper bound on junction count, used to size the flattened cpc vector.
    localparam int MAX_J  = 32;
    localparam int FLAT_W = MAX_J * 32;

    // Drain length in cycle blocks per junction: inference flushes one
    // block per junction, training needs a second pass for the backward sweep.
    localparam int DRAIN_INF_PER_J = 1;
    localparam int DRAIN_TRN_PER_J = 2;

    // Largest of the first n 32-bit entries packed LSB-first in flat.
    function automatic int max_of_array(input logic [FLAT_W-1:0] flat, input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < MAX_J; i++) begin
            if (i < n && flat[i*32 +: 32] > m) m = flat[i*32 +: 32];
        end
        return int'(m);
    endfunction

endpackage

// File: rtl/junc_index_gen.sv
// Maps the master cycle count onto one junction's cycle index: follows mc
// inside the junction's own window, then parks on its last index.
module junc_index_gen
    import dnn_pkg::*;
#(
    parameter int          IW  = 4,
    parameter logic [31:0] CPC = 32'd4
) (
    input  logic [IW-1:0] mc,
    output logic [IW-1:0] idx,
    output logic          active
);

    localparam logic [IW-1:0] IDX_LAST = IW'(CPC - 32'd1);

    // Window test and clamp; shorter junctions idle while longer ones finish.
    always_comb begin
        active = (32'(mc) < CPC);
        idx    = active ? mc : IDX_LAST;
    end

endmodule

// File: rtl/junction_cycle_ctrl.sv
// Epoch/cycle-block sequencer for a multi-junction pipeline.
// Optional feature macro: CYCLE_CTRL_PAUSE_EN adds a 'pause' input that
// freezes the sequencer while busy.
module junction_cycle_ctrl
    import dnn_pkg::*;
#(
    parameter int                    J          = 2,
    parameter logic [0:J-1][31:0]    cpc        = '{32'd10, 32'd6},
    parameter int                    num_inputs = 64,
    localparam int CPCM      = max_of_array(FLAT_W'(cpc), J),
    localparam int IW        = $clog2(CPCM),
    localparam int DRAIN_INF = J * DRAIN_INF_PER_J,
    localparam int DRAIN_TRN = J * DRAIN_TRN_PER_J
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
`ifdef CYCLE_CTRL_PAUSE_EN
    input  logic            pause,
`endif
    output logic            busy,
    output logic            cycle_clk,
    output logic [J*IW-1:0] junc_index,
    output logic [J-1:0]    junc_active,
    output logic            load_en,
    output logic            epoch_done
);

    localparam logic [IW-1:0] MC_LAST      = IW'(CPCM - 1);
    localparam logic [15:0]   IN_LAST      = 16'(num_inputs - 1);
    localparam logic [15:0]   DRN_LAST_INF = 16'(DRAIN_INF - 1);
    localparam logic [15:0]   DRN_LAST_TRN = 16'(DRAIN_TRN - 1);

    cyc_state_e    state_q, state_d;
    logic [IW-1:0] mc_q, mc_d;
    logic [15:0]   in_cnt_q, in_cnt_d;
    logic [15:0]   drn_cnt_q, drn_cnt_d;
    logic          mode_q, mode_d;
    logic          done_q, done_d;
    logic          cyc_clk_q, cyc_clk_d;
    logic          wrap;
    logic          frz;
    logic [J-1:0]  act_raw;

`ifdef CYCLE_CTRL_PAUSE_EN
    assign frz = pause && (state_q != ST_IDLE);
`else
    assign frz = 1'b0;
`endif

    // Next-state: master counter, input/drain block counters and phase FSM.
    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        in_cnt_d  = in_cnt_q;
        drn_cnt_d = drn_cnt_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        wrap      = (mc_q == MC_LAST);
        if (!frz) begin
            unique case (state_q)
                ST_IDLE: begin
                    mc_d      = '0;
                    in_cnt_d  = '0;
                    drn_cnt_d = '0;
                    if (start) begin
                        state_d = ST_RUN;
                        mode_d  = mode;
                    end
                end
                ST_RUN: begin
                    mc_d = wrap ? '0 : mc_q + 1'b1;
                    if (wrap) begin
                        if (in_cnt_q == IN_LAST) begin
                            state_d  = ST_DRAIN;
                            in_cnt_d = '0;
                        end else begin
                            in_cnt_d = in_cnt_q + 16'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    mc_d = wrap ? '0 : mc_q + 1'b1;
                    if (wrap) begin
                        if (drn_cnt_q == (mode_q ? DRN_LAST_INF : DRN_LAST_TRN)) begin
                            state_d   = ST_IDLE;
                            drn_cnt_d = '0;
                            done_d    = 1'b1;
                        end else begin
                            drn_cnt_d = drn_cnt_q + 16'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // Block-start strobe is registered from the next state so it is a clean flop output.
        cyc_clk_d = (state_d != ST_IDLE) && (mc_d == '0);
    end

    // State register with synchronous reset taking priority over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mc_q      <= '0;
            in_cnt_q  <= '0;
            drn_cnt_q <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            cyc_clk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_q      <= mc_d;
            in_cnt_q  <= in_cnt_d;
            drn_cnt_q <= drn_cnt_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            cyc_clk_q <= cyc_clk_d;
        end
    end

    for (genvar j = 0; j < J; j++) begin : g_junc
        junc_index_gen #(
            .IW  (IW),
            .CPC (cpc[j])
        ) u_gen (
            .mc     (mc_q),
            .idx    (junc_index[j*IW +: IW]),
            .active (act_raw[j])
        );
    end

    assign busy        = (state_q != ST_IDLE);
    assign cycle_clk   = cyc_clk_q && !frz;
    assign load_en     = (state_q == ST_RUN);
    assign epoch_done  = done_q;
    assign junc_active = (busy && !frz) ? act_raw : '0;

endmodule

// File: tb/tb_junction_cycle_ctrl.sv
// Bench for junction_cycle_ctrl: two instances (64 and 3 inputs per epoch)
// share stimulus and are checked against an epoch-offset reference model.
module tb_junction_cycle_ctrl;

    localparam int J    = 2;
    localparam int CPCM = 10;
    localparam int IW   = 4;
    localparam int CPC [2] = '{10, 6};
    localparam int NIN [2] = '{64, 3};
`ifdef CYCLE_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, mode;
`ifdef CYCLE_CTRL_PAUSE_EN
    logic pause;
`endif
    logic [1:0]      busy, cycle_clk, load_en, epoch_done;
    logic [J*IW-1:0] junc_index  [2];
    logic [J-1:0]    junc_active [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        junction_cycle_ctrl #(
            .J          (J),
            .cpc        ('{32'd10, 32'd6}),
            .num_inputs (NIN[g])
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start),
            .mode        (mode),
`ifdef CYCLE_CTRL_PAUSE_EN
            .pause       (pause),
`endif
            .busy        (busy[g]),
            .cycle_clk   (cycle_clk[g]),
            .junc_index  (junc_index[g]),
            .junc_active (junc_active[g]),
            .load_en     (load_en[g]),
            .epoch_done  (epoch_done[g])
        );
    end

    // Reference model: clocks elapsed since epoch start (-1 when idle).
    int t_m  [2];
    bit md_m [2];
    bit dn_m [2];
    int n_cmp, n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit m, input bit p);
        bit frz, bz, gate;
        int total, mc, eidx;
        reset = r;
        start = s;
        mode  = m;
`ifdef CYCLE_CTRL_PAUSE_EN
        pause = p;
`endif
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            frz = PAUSE_EN && p && (t_m[g] >= 0);
            if (r) begin
                t_m[g] = -1;
                dn_m[g] = 1'b0;
            end else if (t_m[g] >= 0) begin
                dn_m[g] = 1'b0;
                if (!frz) begin
                    total = (NIN[g] + (md_m[g] ? J : 2 * J)) * CPCM;
                    t_m[g]++;
                    if (t_m[g] == total) begin
                        t_m[g] = -1;
                        dn_m[g] = 1'b1;
                    end
                end
            end else begin
                dn_m[g] = 1'b0;
                if (s) begin
                    t_m[g] = 0;
                    md_m[g] = m;
                end
            end
            bz   = (t_m[g] >= 0);
            mc   = bz ? t_m[g] % CPCM : 0;
            gate = PAUSE_EN && p && bz;
            check($sformatf("busy[%0d]", g), busy[g], bz);
            check($sformatf("cycle_clk[%0d]", g), cycle_clk[g], bz && mc == 0 && !gate);
            check($sformatf("load_en[%0d]", g), load_en[g], bz && t_m[g] < NIN[g] * CPCM);
            check($sformatf("epoch_done[%0d]", g), epoch_done[g], dn_m[g]);
            for (int j = 0; j < J; j++) begin
                eidx = (mc < CPC[j]) ? mc : CPC[j] - 1;
                check($sformatf("junc_index[%0d][%0d]", g, j), junc_index[g][j*IW +: IW], eidx);
                check($sformatf("junc_active[%0d][%0d]", g, j), junc_active[g][j],
                      bz && !gate && mc < CPC[j]);
            end
        end
    endtask

    initial begin
        int busy_cnt, done_cnt, ld_cnt, done_at, idle_cnt;
        n_cmp = 0;
        n_err = 0;
        t_m  = '{-1, -1};
        md_m = '{1'b0, 1'b0};
        dn_m = '{1'b0, 1'b0};
        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
`ifdef CYCLE_CTRL_PAUSE_EN
        pause = 1'b0;
`endif

        // Reset state, then reset overriding a simultaneous start.
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);

        // Full training epoch with a one-clock start; mode wiggles mid-epoch.
        step(0, 1, 0, 0);
        busy_cnt = busy[0];
        done_cnt = 0;
        for (int i = 0; i < 700; i++) begin
            step(0, 0, 1'($urandom_range(0, 1)), 0);
            busy_cnt += busy[0];
            done_cnt += epoch_done[0];
        end
        check("train_busy_len", busy_cnt, 680);
        check("train_done_cnt", done_cnt, 1);

        // Inference epoch: 3-input instance loads for 30 clocks, done at clock 50.
        step(0, 1, 1, 0);
        ld_cnt  = load_en[1];
        done_at = -1;
        for (int i = 1; i <= 700; i++) begin
            step(0, 0, 1'($urandom_range(0, 1)), 0);
            ld_cnt += load_en[1];
            if (epoch_done[1] && done_at < 0) done_at = i;
        end
        check("inf_load_len", ld_cnt, 30);
        check("inf_done_at", done_at, 50);

        // Reset at mc=4 of block 7, then a fresh epoch restarts from input 0.
        step(0, 1, 0, 0);
        for (int i = 0; i < 74; i++) step(0, 0, 0, 0);
        check("pre_reset_mc", junc_index[0][0 +: IW], 4);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 700; i++) step(0, 0, 0, 0);

        // Start held through the epoch and on the epoch_done cycle: back-to-back.
        step(0, 1, 0, 0);
        idle_cnt = 0;
        for (int i = 0; i < 681; i++) begin
            step(0, 1, 0, 0);
            idle_cnt += !busy[0];
        end
        done_cnt = 0;
        for (int i = 0; i < 700; i++) begin
            step(0, 0, 0, 0);
            idle_cnt += (i < 679) ? !busy[0] : 0;
            done_cnt += epoch_done[0];
        end
        check("b2b_idle_cycles", idle_cnt, 1);
        check("b2b_second_done", done_cnt, 1);

`ifdef CYCLE_CTRL_PAUSE_EN
        // Pause 5 clocks at mc=3: mc holds and epoch_done slips by 5.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1);
            check("pause_mc_hold", junc_index[1][0 +: IW], 3);
        end
        done_at = -1;
        for (int i = 9; i <= 100; i++) begin
            step(0, 0, 0, 0);
            if (epoch_done[1] && done_at < 0) done_at = i;
        end
        check("pause_done_at", done_at, 75);
        step(1, 0, 0, 0);
`endif

        // Random traffic: sparse resets, starts, mode flips and pauses.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
